parking_gate_ctrl: RTL
======================

Name: parking_gate_ctrl

Overview:
- Controller for the car-park occupancy datapath: owns the single occupancy counter and sequences the entry and exit barriers around it.
- Consumes per-car pulses from the entry and exit direction decoders (the A/B sensor-sequence FSMs).
- Grants barrier openings against capacity, arbitrates simultaneous counter updates, and flags protocol violations.
- Drives the occupancy display and the full/empty indicators.

Parameters:
CAPACITY, 7, maximum cars; entry barrier refused when count == CAPACITY
CNT_W, 3, width of count output; CAPACITY must be <= 2**CNT_W-1
OPEN_TICKS, 50, cycles a barrier stays OPEN waiting for a pass pulse before closing unused
HOLD_TICKS, 10, cycles a barrier stays open after a pass pulse (car clearing)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ent_req  in  1  level: car waiting at entry
ext_req  in  1  level: car waiting at exit
car_in  in  1  single-cycle pulse: entry decoder completed a valid entry sequence
car_out  in  1  single-cycle pulse: exit decoder completed a valid exit sequence
gate_in  out  1  entry barrier open (1 = open)
gate_out  out  1  exit barrier open
count  out  CNT_W  current occupancy
full  out  1  count == CAPACITY
empty  out  1  count == 0
err  out  1  sticky violation flag, cleared only by reset

Behaviour:
- Reset values (asserted asynchronously, released on clk): gate_in=0, gate_out=0, count=0, full=0, empty=1, err=0; both FSMs in IDLE; timers at 0.
- Two identical registered FSMs, one per gate; states are IDLE, OPEN, HOLD.
- Entry FSM:
  - IDLE -> OPEN when ent_req=1 and full=0. gate_in rises the cycle after ent_req is sampled (1-cycle latency). Timer loads OPEN_TICKS-1.
  - OPEN -> HOLD on car_in=1. Timer loads HOLD_TICKS-1.
  - OPEN -> IDLE when the timer reaches 0 with no car_in. Count is unchanged.
  - HOLD -> IDLE when the timer reaches 0. car_in pulses during HOLD set err and are not counted.
  - gate_in = 1 in OPEN and HOLD.
- Exit FSM: same structure with ext_req, car_out and gate_out. Open condition is empty=0 instead of full=0.
- Timers decrement by 1 per cycle while OPEN or HOLD. OPEN lasts exactly OPEN_TICKS cycles; HOLD lasts exactly HOLD_TICKS cycles.
- Counter arbitration, evaluated each cycle. A pass is valid only when its FSM is in OPEN:
  - inc_ok = car_in and entry OPEN and count < CAPACITY.
  - dec_ok = car_out and exit OPEN and count > 0.
  - inc_ok and dec_ok together: count unchanged (net zero); both FSMs still advance to HOLD.
  - inc_ok only: count+1. dec_ok only: count-1.
  - count updates 1 cycle after the pulse; full and empty are combinational from the count register.
- No wrap-around: count never exceeds CAPACITY and never goes below 0.
- err is set (and held) on any of:
  - car_in while the entry FSM is not in OPEN (tailgate);
  - car_out while the exit FSM is not in OPEN;
  - a pass that would overflow or underflow the count.
- A violating pulse never changes count.
- If ent_req is still high when HOLD completes and full=0, the entry FSM returns to IDLE for one cycle, then re-opens (no back-to-back OPEN without IDLE).
- Reset mid-operation: barriers close immediately (asynchronous), count clears, and timers clear.
- Requests are level-sensitive; a request dropped during OPEN does not close the barrier early.

Test Plan:
- Reset: assert reset for 3 cycles -> gate_in=0, gate_out=0, count=0, empty=1, full=0, err=0.
- Entry: ent_req=1 -> gate_in=1 the next cycle; car_in pulse -> count=1 the next cycle, gate_in held 10 cycles, then 0. Repeat -> count=2.
- Timeout: ent_req=1 with no car_in -> gate_in=1 for exactly 50 cycles, then 0; count unchanged; err=0.
- Full: drive 7 entries -> full=1, count=7; ent_req=1 -> gate_in stays 0. Exit on empty: ext_req=1 at count=0 -> gate_out stays 0.
- Simultaneous: count=3, both gates OPEN, car_in and car_out in the same cycle -> count stays 3; both gates go to HOLD.
- Violations: car_in with gate_in=0 -> err=1, count unchanged. Assert reset while gate_out=1 -> gate_out=0 immediately, err=0, count=0.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
// Car-park occupancy controller. It owns the single occupancy counter and runs
// one barrier FSM per gate (index 0 = entry, index 1 = exit). Each FSM has three
// states: IDLE, OPEN and HOLD. OPEN waits for a pass pulse. HOLD keeps the barrier
// up while the car clears. Pass pulses update the counter only when their gate is
// OPEN. Any other pulse, or a pass that would overflow or underflow the counter,
// sets the sticky err flag.
//
// Request/gate relation: ent_req/ext_req are levels. The controller does not
// acknowledge them. A request is sampled only while its FSM is IDLE and the
// capacity check allows it. The gate output is the only response, and it follows
// one cycle after the sample. car_in/car_out are single-cycle pulses. A pulse
// counts as a valid pass only in a cycle where the matching gate FSM is OPEN.
module parking_gate_ctrl #(
  parameter int CAPACITY   = 7,
  parameter int CNT_W      = 3,
  parameter int OPEN_TICKS = 50,
  parameter int HOLD_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ent_req,
  input  logic             ext_req,
  input  logic             car_in,
  input  logic             car_out,
  output logic             gate_in,
  output logic             gate_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err,
  output logic [1:0]       dbg_ent_state,
  output logic [1:0]       dbg_ext_state
);

  // Barrier FSM encoding, shared by both gates.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OPEN = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // The timer must hold values up to the larger of the two phase lengths minus one.
  localparam int TMAX = (OPEN_TICKS > HOLD_TICKS) ? OPEN_TICKS : HOLD_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]    OPEN_LD = TW'(OPEN_TICKS - 1);
  localparam logic [TW-1:0]    HOLD_LD = TW'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAPACITY);

  // Per-gate state. Index 0 is the entry gate and index 1 is the exit gate.
  logic [1:0]       r_state    [2];
  logic [TW-1:0]    r_timer    [2];
  logic [1:0]       w_state_nx [2];
  logic [TW-1:0]    w_timer_nx [2];

  logic [1:0]       w_req;
  logic [1:0]       w_pass;
  logic [1:0]       w_allow;
  logic [1:0]       w_is_open;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nx;
  logic             r_err;
  logic             w_full;
  logic             w_empty;
  logic             w_inc_ok;
  logic             w_dec_ok;
  logic             w_viol;

  // Gather per-gate inputs so both FSMs share a single next-state description.
  always_comb begin
    w_req        = {ext_req, ent_req};
    w_pass       = {car_out, car_in};
    w_allow      = {~w_empty, ~w_full};
    w_is_open[0] = (r_state[0] == S_OPEN);
    w_is_open[1] = (r_state[1] == S_OPEN);
  end

  // Barrier FSM next state and timer. A pass pulse takes priority over the
  // OPEN timeout, so a car arriving in the last OPEN cycle is still held.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      w_state_nx[g] = r_state[g];
      w_timer_nx[g] = r_timer[g];
      case (r_state[g])
        S_IDLE: begin
          if (w_req[g] && w_allow[g]) begin
            w_state_nx[g] = S_OPEN;
            w_timer_nx[g] = OPEN_LD;
          end
        end
        S_OPEN: begin
          if (w_pass[g]) begin
            w_state_nx[g] = S_HOLD;
            w_timer_nx[g] = HOLD_LD;
          end else if (r_timer[g] == '0) begin
            w_state_nx[g] = S_IDLE;
            w_timer_nx[g] = '0;
          end else begin
            w_timer_nx[g] = r_timer[g] - TW'(1);
          end
        end
        S_HOLD: begin
          // Always pass through IDLE after HOLD, even if the request is still
          // present. This forces a fresh capacity check before re-opening.
          if (r_timer[g] == '0) begin
            w_state_nx[g] = S_IDLE;
            w_timer_nx[g] = '0;
          end else begin
            w_timer_nx[g] = r_timer[g] - TW'(1);
          end
        end
        default: begin
          w_state_nx[g] = S_IDLE;
          w_timer_nx[g] = '0;
        end
      endcase
    end
  end

  // Barrier FSM registers. Reset closes both barriers immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < 2; g++) begin
        r_state[g] <= S_IDLE;
        r_timer[g] <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        r_state[g] <= w_state_nx[g];
        r_timer[g] <= w_timer_nx[g];
      end
    end
  end

  // Counter arbitration and violation detection. Only pulses seen while the
  // matching gate is OPEN can move the count. Bounds are checked so the
  // count never wraps.
  always_comb begin
    w_inc_ok = car_in  && w_is_open[0] && (r_count < CAP_V);
    w_dec_ok = car_out && w_is_open[1] && (r_count != '0);
    w_viol   = (car_in  && !w_is_open[0])
            || (car_out && !w_is_open[1])
            || (car_in  &&  w_is_open[0] && (r_count >= CAP_V))
            || (car_out &&  w_is_open[1] && (r_count == '0));
    w_count_nx = r_count;
    case ({w_inc_ok, w_dec_ok})
      2'b10:   w_count_nx = r_count + CNT_W'(1);
      2'b01:   w_count_nx = r_count - CNT_W'(1);
      default: w_count_nx = r_count;
    endcase
  end

  // Occupancy counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nx;
    end
  end

  // Sticky violation flag. Only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_viol) begin
      r_err <= 1'b1;
    end
  end

  // Indicators are decoded directly from the registered count.
  always_comb begin
    w_full  = (r_count == CAP_V);
    w_empty = (r_count == '0);
  end

  // Output mapping. The barrier is up in both OPEN and HOLD.
  always_comb begin
    gate_in       = (r_state[0] != S_IDLE);
    gate_out      = (r_state[1] != S_IDLE);
    count         = r_count;
    full          = w_full;
    empty         = w_empty;
    err           = r_err;
    dbg_ent_state = r_state[0];
    dbg_ext_state = r_state[1];
  end

endmodule
